// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: synchronizes the PS2 end-of-byte flag, folds E0/F0 prefixes into
// single key events, queues them in a show-ahead FIFO and tracks shift/ctrl/alt state.
module ps2_scan_decoder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       end_scan,
   input  logic       key_ready,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_release,
   output logic       shift,
   output logic       ctrl,
   output logic       alt,
   output logic       overflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last_q;
   logic                   byte_strobe;
   logic [7:0]             byte_q;
   logic                   byte_vld_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q      <= '0;
         sync_last_q <= 1'b0;
         byte_q      <= 8'h00;
         byte_vld_q  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], end_scan};
         sync_last_q <= sync_q[SYNC_STAGES-1];
         byte_vld_q  <= byte_strobe;
         if (byte_strobe) byte_q <= scan_code;
      end
   end

   assign byte_strobe = sync_q[SYNC_STAGES-1] & ~sync_last_q;

   // Prefix decoding on the registered byte
   state_e state_q, state_d;
   logic   push, ev_ext, ev_rel;
   logic   is_pad, is_e0, is_e1, is_f0, is_ignored;

   assign is_pad     = (byte_q == 8'h00) || (byte_q == 8'hFF);
   assign is_e0      = (byte_q == 8'hE0);
   assign is_e1      = (byte_q == 8'hE1);
   assign is_f0      = (byte_q == 8'hF0);
   assign is_ignored = is_pad || is_e1 || (byte_q == 8'hAA) || (byte_q == 8'hFA);

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      ev_ext  = 1'b0;
      ev_rel  = 1'b0;
      if (byte_vld_q) begin
         unique case (state_q)
            StIdle: begin
               if (is_e0)            state_d = StExt;
               else if (is_f0)       state_d = StBrk;
               else if (!is_ignored) push    = 1'b1;
            end
            StExt: begin
               ev_ext = 1'b1;
               if (is_f0) begin
                  state_d = StExtBrk;
               end else if (!is_e0) begin
                  state_d = StIdle;
                  push    = !is_pad;
               end
            end
            StBrk: begin
               ev_rel  = 1'b1;
               state_d = StIdle;
               push    = !(is_pad || is_e0 || is_e1);
            end
            StExtBrk: begin
               ev_ext  = 1'b1;
               ev_rel  = 1'b1;
               state_d = StIdle;
               push    = !(is_pad || is_e0 || is_e1 || is_f0);
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Modifier tracking follows every decoded event, even one the FIFO drops
   logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         lctrl_q  <= 1'b0;
         rctrl_q  <= 1'b0;
         lalt_q   <= 1'b0;
         ralt_q   <= 1'b0;
      end else if (push) begin
         if (!ev_ext && byte_q == 8'h12) lshift_q <= !ev_rel;
         if (!ev_ext && byte_q == 8'h59) rshift_q <= !ev_rel;
         if (byte_q == 8'h14) begin
            if (ev_ext) rctrl_q <= !ev_rel;
            else        lctrl_q <= !ev_rel;
         end
         if (byte_q == 8'h11) begin
            if (ev_ext) ralt_q <= !ev_rel;
            else        lalt_q <= !ev_rel;
         end
      end
   end

   assign shift = lshift_q | rshift_q;
   assign ctrl  = lctrl_q | rctrl_q;
   assign alt   = lalt_q | ralt_q;

   logic [9:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            overflow_q;
   logic            full, pop, wr_en;
   logic [9:0]      head;

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign pop   = key_valid & key_ready;
   assign wr_en = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {ev_ext, ev_rel, byte_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (wr_en && !pop)      count_q <= count_q + CntW'(1);
         else if (!wr_en && pop) count_q <= count_q - CntW'(1);
         if (push && full && !pop) overflow_q <= 1'b1;
      end
   end

   assign head        = mem_q[rd_ptr_q];
   assign key_valid   = (count_q != '0);
   // Head fields are forced low when empty so stale entries never leak out
   assign key_code    = key_valid ? head[7:0] : 8'h00;
   assign key_release = key_valid & head[8];
   assign key_ext     = key_valid & head[9];
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: byte-level reference model checked every cycle, plus directed
// scenarios with literal expected events.
module tb_ps2_scan_decoder;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       end_scan = 1'b0;
   logic       key_ready = 1'b0;
   logic       key_valid, key_ext, key_release, shift, ctrl, alt, overflow;
   logic [7:0] key_code;

   always #5 clk = ~clk;

   ps2_scan_decoder #(
      .SYNC_STAGES (SYNC),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .scan_code   (scan_code),
      .end_scan    (end_scan),
      .key_ready   (key_ready),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ext     (key_ext),
      .key_release (key_release),
      .shift       (shift),
      .ctrl        (ctrl),
      .alt         (alt),
      .overflow    (overflow)
   );

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   // Reference model state: queued events {ext, rel, code}, prefix flags, held keys
   typedef struct {
      logic [7:0] b;
      int         due;
   } pend_t;

   pend_t      pend[$];
   logic [9:0] m_q[$];
   logic [9:0] dut_log[$];
   bit         m_ovf, m_ext, m_brk;
   bit         m_lsh, m_rsh, m_lct, m_rct, m_lal, m_ral;
   int         cyc = 0;

   task automatic model_clear();
      pend.delete();
      m_q.delete();
      m_ovf = 0; m_ext = 0; m_brk = 0;
      m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_lal = 0; m_ral = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] e);
      bit pad;
      pad = (b == 8'h00) || (b == 8'hFF);
      ev  = 0;
      e   = '0;
      if (!m_ext && !m_brk) begin
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else if (!(pad || b == 8'hE1 || b == 8'hAA || b == 8'hFA)) begin
            ev = 1; e = {2'b00, b};
         end
      end else if (m_ext && !m_brk) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b != 8'hE0) begin
            m_ext = 0;
            if (!pad) begin ev = 1; e = {2'b10, b}; end
         end
      end else begin
         if (!(pad || b == 8'hE0 || b == 8'hE1 || (m_ext && b == 8'hF0))) begin
            ev = 1; e = {m_ext, 1'b1, b};
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   initial begin
      bit         pop, ev;
      logic [9:0] e;
      model_clear();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            model_clear();
         end else begin
            cyc++;
            pop = (m_q.size() != 0) && key_ready;
            ev  = 0;
            e   = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
               model_byte(pend[0].b, ev, e);
               void'(pend.pop_front());
            end
            if (ev) begin
               if (!e[9] && e[7:0] == 8'h12) m_lsh = !e[8];
               if (!e[9] && e[7:0] == 8'h59) m_rsh = !e[8];
               if (e[7:0] == 8'h14) begin if (e[9]) m_rct = !e[8]; else m_lct = !e[8]; end
               if (e[7:0] == 8'h11) begin if (e[9]) m_ral = !e[8]; else m_lal = !e[8]; end
               if (m_q.size() == DEPTH && !pop) m_ovf = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (ev && m_q.size() < DEPTH) m_q.push_back(e);
         end
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle
   initial begin
      logic [13:0] got, exp;
      forever begin
         @(negedge clk);
         if (started) begin
            tests++;
            if (!reset) begin
               got = {key_valid, key_ext, key_release, key_code, shift, ctrl, alt};
               if (got != 14'h0 || overflow !== 1'b0) begin
                  fails++;
                  $display("FAIL reset_outputs t=%0t: got %h ovf=%b, expected all zero",
                           $time, got, overflow);
               end
            end else begin
               got = {key_valid, key_valid ? {key_ext, key_release, key_code} : 10'h0,
                      shift, ctrl, alt};
               exp = {m_q.size() != 0, m_q.size() != 0 ? m_q[0] : 10'h0,
                      m_lsh | m_rsh, m_lct | m_rct, m_lal | m_ral};
               if (got !== exp || overflow !== m_ovf) begin
                  fails++;
                  $display("FAIL model_cycle t=%0t: {vld,ext,rel,code,sh,ct,al}=%h ovf=%b, expected %h ovf=%b",
                           $time, got, overflow, exp, m_ovf);
               end
            end
            if (reset && key_valid && key_ready)
               dut_log.push_back({key_ext, key_release, key_code});
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] log_at(input int i);
      return (dut_log.size() > i) ? dut_log[i] : 10'h3FF;
   endfunction

   // Called just after a rising edge; holds end_scan for 6 cycles, then idles 6 more
   task automatic send(input logic [7:0] b, input bit pulse_ready);
      pend_t p;
      p.b   = b;
      p.due = cyc + int'(SYNC) + 2;
      pend.push_back(p);
      scan_code = b;
      end_scan  = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) end_scan = 1'b0;
         if (pulse_ready && k == 3) key_ready = 1'b1;
         if (pulse_ready && k == 4) key_ready = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      #2 reset = 1'b0;
      started = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", key_valid, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single make code
      key_ready = 1'b1;
      dut_log.delete();
      send(8'h1C, 0);
      chk("make_count", dut_log.size(), 1);
      chk("make_event", log_at(0), 10'h01C);

      // Break
      dut_log.delete();
      send(8'hF0, 0); send(8'h1C, 0);
      chk("break_count", dut_log.size(), 1);
      chk("break_event", log_at(0), 10'h11C);

      // Extended break then extended make
      dut_log.delete();
      send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
      send(8'hE0, 0); send(8'h75, 0);
      chk("ext_count", dut_log.size(), 2);
      chk("ext_break", log_at(0), 10'h375);
      chk("ext_make", log_at(1), 10'h275);

      // Modifiers
      send(8'h12, 0);                 chk("lshift_make", shift, 1);
      send(8'h59, 0);                 chk("rshift_make", shift, 1);
      send(8'hF0, 0); send(8'h12, 0); chk("lshift_break", shift, 1);
      send(8'hF0, 0); send(8'h59, 0); chk("rshift_break", shift, 0);
      dut_log.delete();
      send(8'hE0, 0); send(8'h12, 0); chk("fake_shift", shift, 0);
      chk("fake_shift_event", log_at(0), 10'h212);
      send(8'hE0, 0); send(8'h14, 0); chk("rctrl_make", ctrl, 1);
      chk("alt_idle", alt, 0);

      // Reset mid-sequence with an event buffered and ctrl held
      key_ready = 1'b0;
      send(8'h2C, 0);
      chk("buffered_before_reset", key_valid, 1);
      send(8'hE0, 0);
      #3 reset = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_valid", key_valid, 0);
      chk("midrst_ctrl", ctrl, 0);
      chk("midrst_code", key_code, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      key_ready = 1'b1;
      dut_log.delete();
      send(8'h1C, 0);
      chk("post_reset_count", dut_log.size(), 1);
      chk("post_reset_event", log_at(0), 10'h01C);

      // Overflow: six makes with the consumer stalled
      do_reset();
      key_ready = 1'b0;
      send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0);
      send(8'h2D, 0); send(8'h2C, 0); send(8'h35, 0);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", key_valid, 1);
      chk("ovf_head", key_code, 8'h15);
      dut_log.delete();
      key_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("drain_count", dut_log.size(), 4);
      chk("drain0", log_at(0), 10'h015);
      chk("drain1", log_at(1), 10'h01D);
      chk("drain2", log_at(2), 10'h024);
      chk("drain3", log_at(3), 10'h02D);
      chk("drain_empty", key_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Full FIFO: push coinciding with a pop
      do_reset();
      key_ready = 1'b0;
      send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0);
      dut_log.delete();
      send(8'h2C, 1);
      chk("simul_no_ovf", overflow, 0);
      chk("simul_head", key_code, 8'h1D);
      key_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("simul_count", dut_log.size(), 5);
      chk("simul0", log_at(0), 10'h015);
      chk("simul4", log_at(4), 10'h02C);
      chk("simul_empty", key_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Downstream of the PS2 serial reader; consumes its 8-bit parallel scan code and end-of-packet flag, both in the PS2 clock domain.
- Synchronizes the end-of-packet flag into the system clock domain and decodes scan-code set 2 prefix sequences (E0 extended, F0 break) into single key events.
- Buffers events in a small FIFO with a valid/ready handshake and tracks shift/ctrl/alt modifier state for the character-mapping stage that follows.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the end_scan synchronizer (min 2)
FIFO_DEPTH, 4, event FIFO entries (power of two, min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
scan_code  input  8  byte from PS2 reader; stable while end_scan is high
end_scan  input  1  PS2-domain flag, high for about one PS2 clock period per received byte
key_ready  input  1  consumer accepts the head event when high with key_valid
key_valid  output  1  head FIFO entry present
key_code  output  8  scan code of the head event (prefixes stripped)
key_ext  output  1  head event was E0-prefixed
key_release  output  1  head event is a break (key up)
shift, ctrl, alt  output  1 each  current modifier held state
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0, FSM in IDLE, FIFO empty, synchronizer cleared.
  - Reset asserted mid-sequence (e.g. after E0) discards the partial sequence.
- Synchronizer and strobe:
  - end_scan passes through SYNC_STAGES flops, followed by one edge-detect flop.
  - byte_strobe is a 1-cycle pulse on the rising edge of the synchronized flag.
  - scan_code is sampled into a byte register on the byte_strobe cycle. It is stable there because end_scan lasts far longer than SYNC_STAGES+1 clk cycles.
  - One strobe per end_scan pulse, regardless of pulse length.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions act on the registered byte, one cycle after byte_strobe.
  - IDLE: E0 -> EXT; F0 -> BRK; E1, 00, FF, AA, FA discarded, stay IDLE; any other byte pushes {ext=0, rel=0, code}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 stays EXT; 00/FF -> IDLE with no push; other byte pushes {1, 0, code} -> IDLE.
  - BRK: 00/FF/E0/E1 -> IDLE with no push; other byte pushes {0, 1, code} -> IDLE.
  - EXT_BRK: 00/FF/E0/E1/F0 -> IDLE with no push; other byte pushes {1, 1, code} -> IDLE.
  - The fake-shift sequences E0 12 and E0 F0 12 are pushed as normal ext events and do not change modifiers.
- Modifiers update in the same cycle as the push; the update happens even if the push is dropped for overflow.
  - shift = lshift (12, ext=0) OR rshift (59, ext=0).
  - ctrl = 14 with ext 0 or 1.
  - alt = 11 with ext 0 or 1.
  - Make sets the held bit, break clears it; left and right keys are tracked separately internally.
- FIFO:
  - Entries are 10 bits {ext, rel, code}; show-ahead, so key_code/key_ext/key_release reflect the head entry whenever key_valid=1.
  - Pop when key_valid and key_ready are both high.
  - Push with FIFO full and no pop in the same cycle: the event is dropped and overflow is set, cleared only by reset.
  - Push with FIFO full and a pop in the same cycle: both succeed and the count is unchanged.
  - Push and pop with the FIFO empty: not possible in the same cycle, because key_valid is 0.
  - Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Latency with the FIFO empty: key_valid rises 2 cycles after byte_strobe (register byte, then push).
  - key_valid drops the cycle after the last pop.
  - Holding key_ready=1 consumes one event per cycle.

Test Plan:
- Byte 1C with key_ready=1 -> one key_valid pulse with key_code=1C, ext=0, rel=0, exactly 2 cycles after byte_strobe; no further events.
- Sequence F0 1C -> single event {0, 1, 1C}; no event emitted for F0.
- Sequence E0 F0 75 -> single event {1, 1, 75}; then E0 75 -> {1, 0, 75}; FSM returns to IDLE after each.
- Modifier tracking:
  - 12 -> shift=1; then 59 -> shift=1; then F0 12 -> shift stays 1; then F0 59 -> shift=0.
  - E0 14 -> ctrl=1.
- key_ready=0, six make codes 15, 1D, 24, 2D, 2C, 35:
  - First four are buffered, overflow=1, key_code=15.
  - Raising key_ready pops 15, 1D, 24, 2D on consecutive cycles, then key_valid=0.
  - Also with FIFO full: a push coinciding with a pop keeps the count at 4 and does not set overflow.
- Reset pulled low after E0 has been received, then released, then 1C -> event {0, 0, 1C}; all outputs are 0 during reset.
